// File: rtl/cr_kme_fifo_packer.sv
// Packs RATIO narrow upstream beats into one wide word and pushes it into the KME FIFO.
// Optional statistics counters are built when CR_KME_FIFO_PACKER_STATS_EN is defined.
module cr_kme_fifo_packer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] fifo_in,
  output logic                 fifo_in_valid,
  input  logic                 fifo_in_stall,
  output logic [31:0]          stat_words,
  output logic [31:0]          stat_stalls
);

  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W = $clog2(RATIO) + 1;

  generate
    if (((OUT_WIDTH % IN_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_params
      $error("cr_kme_fifo_packer: OUT_WIDTH must be a multiple (>=2x) of IN_WIDTH");
    end
  endgenerate

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] hold_data;
  logic [OUT_WIDTH-1:0] merged;
  logic [CNT_W-1:0]     cnt;
  logic                 hold_valid;
  logic                 push;
  logic                 accept;
  logic                 complete;

  assign push          = rst_n & hold_valid & ~fifo_in_stall;
  assign fifo_in_valid = push;
  // The holding register frees up in the same cycle it pushes, allowing full rate.
  assign in_ready      = rst_n & (~hold_valid | push);
  assign accept        = in_valid & in_ready;
  assign complete      = accept & (in_last | (cnt == CNT_W'(RATIO - 1)));
  assign fifo_in       = hold_data;

  always_comb begin
    merged = acc;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt == CNT_W'(i)) begin
        merged[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (complete) begin
          hold_data <= merged;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= merged;
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (complete) begin
        hold_valid <= 1'b1;
      end else if (push) begin
        hold_valid <= 1'b0;
      end
    end
  end

`ifdef CR_KME_FIFO_PACKER_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (push && (words_q != 32'hFFFF_FFFF)) begin
        words_q <= words_q + 32'd1;
      end
      if (hold_valid && fifo_in_stall && (stalls_q != 32'hFFFF_FFFF)) begin
        stalls_q <= stalls_q + 32'd1;
      end
    end
  end

  assign stat_words  = words_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_words  = 32'h0;
  assign stat_stalls = 32'h0;
`endif

endmodule

// File: tb/tb_cr_kme_fifo_packer.sv
// Directed bench for cr_kme_fifo_packer; stats expectations follow CR_KME_FIFO_PACKER_STATS_EN.
module tb_cr_kme_fifo_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [255:0] fifo_in;
  logic         fifo_in_valid;
  logic         fifo_in_stall = 1'b0;
  logic [31:0]  stat_words;
  logic [31:0]  stat_stalls;

  int errors = 0;
  int checks = 0;

`ifdef CR_KME_FIFO_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  cr_kme_fifo_packer #(.IN_WIDTH(64), .OUT_WIDTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(fifo_in_stall), .stat_words(stat_words), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic beat(input logic [63:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    fifo_in_stall = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [255:0] w4(input logic [63:0] l3, input logic [63:0] l2,
                                      input logic [63:0] l1, input logic [63:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic test_reset;
    tick();
    checks++; if (fifo_in_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", fifo_in_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", in_ready); end
    checks++; if (fifo_in !== 256'h0) begin errors++; $display("FAIL rst_data: got %h want 0", fifo_in); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0b want 1", in_ready); end
    checks++; if (stat_words !== 32'h0) begin errors++; $display("FAIL rst_stat_words: got %0d want 0", stat_words); end
    checks++; if (stat_stalls !== 32'h0) begin errors++; $display("FAIL rst_stat_stalls: got %0d want 0", stat_stalls); end
  endtask

  task automatic test_full_word;
    logic [63:0] d [4];
    d[0] = 64'h1111_1111_1111_1111;
    d[1] = 64'h2222_2222_2222_2222;
    d[2] = 64'h3333_3333_3333_3333;
    d[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) begin
      beat(d[i], 1'b0);
      #1;
      checks++; if (fifo_in_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid[%0d]: got %0b want 0", i, fifo_in_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d]: got %0b want 1", i, in_ready); end
      tick();
    end
    idle();
    #1;
    checks++; if (fifo_in_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %0b want 1", fifo_in_valid); end
    checks++; if (fifo_in !== w4(d[3], d[2], d[1], d[0])) begin errors++; $display("FAIL full_data: got %h want %h", fifo_in, w4(d[3], d[2], d[1], d[0])); end
    tick();
    checks++; if (fifo_in_valid !== 1'b0) begin errors++; $display("FAIL full_single_push: got %0b want 0", fifo_in_valid); end
  endtask

  task automatic test_last;
    logic [63:0] a, b, x;
    a = 64'hA5A5_A5A5_A5A5_A5A5;
    b = 64'h5A5A_5A5A_5A5A_5A5A;
    x = 64'h0123_4567_89AB_CDEF;
    beat(a, 1'b0);
    tick();
    beat(b, 1'b1);
    tick();
    beat(x, 1'b1);
    #1;
    checks++; if (fifo_in_valid !== 1'b1) begin errors++; $display("FAIL last_valid: got %0b want 1", fifo_in_valid); end
    checks++; if (fifo_in !== {128'h0, b, a}) begin errors++; $display("FAIL last_data: got %h want %h", fifo_in, {128'h0, b, a}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL last_ready: got %0b want 1", in_ready); end
    tick();
    idle();
    #1;
    checks++; if (fifo_in_valid !== 1'b1) begin errors++; $display("FAIL last_lane0_valid: got %0b want 1", fifo_in_valid); end
    checks++; if (fifo_in !== {192'h0, x}) begin errors++; $display("FAIL last_lane0_data: got %h want %h", fifo_in, {192'h0, x}); end
    tick();
    checks++; if (fifo_in_valid !== 1'b0) begin errors++; $display("FAIL last_idle: got %0b want 0", fifo_in_valid); end
  endtask

  task automatic test_stall;
    logic [63:0] w, n;
    w = 64'hDEAD_BEEF_CAFE_F00D;
    n = 64'h0BAD_F00D_1234_5678;
    do_reset();
    fifo_in_stall = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ignored_empty: got %0b want 1", in_ready); end
    beat(w, 1'b1);
    tick();
    beat(n, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (fifo_in_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %0b want 0", i, fifo_in_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %0b want 0", i, in_ready); end
      checks++; if (fifo_in !== {192'h0, w}) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, fifo_in, {192'h0, w}); end
      tick();
    end
    fifo_in_stall = 1'b0;
    #1;
    checks++; if (fifo_in_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %0b want 1", fifo_in_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b want 1", in_ready); end
    checks++; if (fifo_in !== {192'h0, w}) begin errors++; $display("FAIL stall_release_data: got %h want %h", fifo_in, {192'h0, w}); end
    checks++; if (stat_stalls !== (STATS ? 32'd5 : 32'd0)) begin errors++; $display("FAIL stall_stat: got %0d want %0d", stat_stalls, STATS ? 5 : 0); end
    tick();
    idle();
    #1;
    checks++; if (fifo_in_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid: got %0b want 1", fifo_in_valid); end
    checks++; if (fifo_in !== {192'h0, n}) begin errors++; $display("FAIL stall_next_data: got %h want %h", fifo_in, {192'h0, n}); end
    tick();
    checks++; if (fifo_in_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %0b want 0", fifo_in_valid); end
    checks++; if (stat_words !== (STATS ? 32'd2 : 32'd0)) begin errors++; $display("FAIL stall_stat_words: got %0d want %0d", stat_words, STATS ? 2 : 0); end
  endtask

  task automatic test_back_to_back;
    int pushes;
    logic exp_v;
    logic [255:0] exp_w;
    pushes = 0;
    for (int i = 0; i < 16; i++) begin
      beat(64'(i + 1), 1'b0);
      #1;
      exp_v = (i > 0) && ((i % 4) == 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, in_ready); end
      checks++; if (fifo_in_valid !== exp_v) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b want %0b", i, fifo_in_valid, exp_v); end
      if (fifo_in_valid === 1'b1) pushes++;
      if (exp_v) begin
        exp_w = w4(64'(i), 64'(i - 1), 64'(i - 2), 64'(i - 3));
        checks++; if (fifo_in !== exp_w) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, fifo_in, exp_w); end
      end
      tick();
    end
    idle();
    #1;
    exp_w = w4(64'd16, 64'd15, 64'd14, 64'd13);
    checks++; if (fifo_in_valid !== 1'b1) begin errors++; $display("FAIL b2b_last_valid: got %0b want 1", fifo_in_valid); end
    checks++; if (fifo_in !== exp_w) begin errors++; $display("FAIL b2b_last_data: got %h want %h", fifo_in, exp_w); end
    if (fifo_in_valid === 1'b1) pushes++;
    tick();
    checks++; if (pushes != 4) begin errors++; $display("FAIL b2b_push_count: got %0d want 4", pushes); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] c, d, e, f;
    c = 64'hC0C0_C0C0_C0C0_C0C0;
    d = 64'hD0D0_D0D0_D0D0_D0D0;
    e = 64'hE0E0_E0E0_E0E0_E0E0;
    f = 64'hF0F0_F0F0_F0F0_F0F0;
    beat(64'hBAD0_0000_0000_0001, 1'b0);
    tick();
    beat(64'hBAD0_0000_0000_0002, 1'b0);
    tick();
    rst_n = 1'b0;
    beat(64'hBAD0_0000_0000_0003, 1'b0);
    #1;
    checks++; if (fifo_in_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b want 0", fifo_in_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %0b want 0", in_ready); end
    tick();
    rst_n = 1'b1;
    beat(c, 1'b0); tick();
    beat(d, 1'b0); tick();
    beat(e, 1'b0); tick();
    beat(f, 1'b0); tick();
    idle();
    #1;
    checks++; if (fifo_in_valid !== 1'b1) begin errors++; $display("FAIL rmid_word_valid: got %0b want 1", fifo_in_valid); end
    checks++; if (fifo_in !== w4(f, e, d, c)) begin errors++; $display("FAIL rmid_word_data: got %h want %h", fifo_in, w4(f, e, d, c)); end
    tick();
    beat(64'h7777_0000_0000_7777, 1'b1);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_in_valid !== 1'b0) begin errors++; $display("FAIL rhold_valid: got %0b want 0", fifo_in_valid); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (fifo_in_valid !== 1'b0) begin errors++; $display("FAIL rhold_dropped: got %0b want 0", fifo_in_valid); end
    checks++; if (fifo_in !== 256'h0) begin errors++; $display("FAIL rhold_data: got %h want 0", fifo_in); end
  endtask

  task automatic test_stats;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      beat(64'(k + 100), 1'b1);
      tick();
      idle();
      tick();
    end
    #1;
    checks++; if (stat_words !== (STATS ? 32'd3 : 32'd0)) begin errors++; $display("FAIL stats_words: got %0d want %0d", stat_words, STATS ? 3 : 0); end
    checks++; if (stat_stalls !== 32'd0) begin errors++; $display("FAIL stats_stalls: got %0d want 0", stat_stalls); end
    checks++; if (fifo_in !== {192'h0, 64'd102}) begin errors++; $display("FAIL stats_last_word: got %h want %h", fifo_in, {192'h0, 64'd102}); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_last();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
